thread_scheduler: RTL and testbench
===================================

Name: thread_scheduler

Overview:
- Fetch-side scheduler for the fine-grained multithreaded RV32 pipeline.
- Owns one PC per hardware thread and picks one eligible thread per cycle, round-robin; drives tid_f/pc_f/pc_plus4_f into fetch/decode.
- Parks a thread while its branch/jump is unresolved and releases it on execute resolution, so no thread ever fetches down a wrong path (no flush logic needed).

Parameters:
- NUM_THREADS, 4, hardware thread count (power of two, >=2).
- ADDRESS_WIDTH, 32, PC width.
- RESET_PC, 32'h0000_0000, start PC loaded into every thread on reset.
- BITS_THREADS (localparam), $clog2(NUM_THREADS), thread-id width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en_mask  in  NUM_THREADS  per-thread run enable.
- stall_f  in  1  global fetch stall from hazard unit.
- dec_valid  in  1  decode holds a valid instruction this cycle (not stalled, not bubble).
- dec_tid  in  BITS_THREADS  thread of that instruction (tid_d).
- dec_ctrl  in  1  that instruction is branch_d|jump_d.
- res_valid  in  1  execute resolves a control instruction this cycle.
- res_tid  in  BITS_THREADS  its thread.
- res_taken  in  1  redirect required.
- res_target  in  ADDRESS_WIDTH  redirect PC.
- fetch_valid_f  out  1  tid_f/pc_f describe a real fetch.
- tid_f  out  BITS_THREADS  fetched thread.
- pc_f  out  ADDRESS_WIDTH  fetch PC.
- pc_plus4_f  out  ADDRESS_WIDTH  pc_f+4.

Behaviour:
- Per-thread 2-bit state: IDLE, READY, INFLIGHT, BLOCKED.
- Reset (rst high at edge): all threads IDLE; all PCs = RESET_PC; RR pointer = NUM_THREADS-1 (so thread 0 wins first); fetch_valid_f=0, tid_f=0, pc_f=RESET_PC, pc_plus4_f=RESET_PC+4. Reset mid-operation discards all state in the same edge.
- Eligible(t) = state READY and en_mask[t]. Pick is combinational: first eligible thread at or after pointer+1, modulo NUM_THREADS.
- Issue when eligible thread exists and !stall_f:
  - Next edge: outputs register tid, pc[t], pc[t]+4, with fetch_valid_f=1.
  - pc[t] <= pc[t]+4; state[t] <= INFLIGHT; pointer <= t.
  - Latency: one cycle from pick to outputs.
- No issue (stall_f, or nothing eligible): if stall_f, outputs hold all values including fetch_valid_f. If not stalled with nothing eligible, fetch_valid_f <= 0 and the other outputs hold.
- State transitions:
  - IDLE -> READY when en_mask[t]=1.
  - READY -> IDLE when en_mask[t]=0.
  - INFLIGHT -> BLOCKED on dec_valid & dec_tid==t & dec_ctrl.
  - INFLIGHT -> READY on dec_valid & dec_tid==t & !dec_ctrl.
  - BLOCKED -> READY on res_valid & res_tid==t. If res_taken, pc[t] <= res_target; otherwise pc[t] is unchanged (already +4).
  - INFLIGHT and BLOCKED ignore en_mask. A disabled thread drains to READY and then to IDLE on the following cycle.
- Simultaneous events:
  - Decode report and resolution for different threads in the same cycle: both apply.
  - Resolution for thread t and a pick in the same cycle: t is not eligible until the next cycle; the pick uses registered state.
  - A thread is issued at most once per pick; with a single enabled thread it fetches at most every 2 cycles (INFLIGHT gap).
- Illegal inputs, which are assertion targets:
  - dec_valid for a thread not INFLIGHT.
  - res_valid for a thread not BLOCKED.
  - Both are ignored in RTL, with no state change.
- Arithmetic: PC add wraps modulo 2^ADDRESS_WIDTH; RR pointer wraps modulo NUM_THREADS.

Decomposition:
- Shared package mt_pkg:
  - thread_state_t enum: IDLE=0, READY=1, INFLIGHT=2, BLOCKED=3.
  - BITS_THREADS helper and RESET_PC default, shared with mt_reg_file and decode.
- One sub-module rr_arbiter (NUM_THREADS): request vector plus pointer in, one-hot/index grant and valid out, purely combinational.
- PC array and state FSMs live in thread_scheduler.

Test Plan:
- Reset, en_mask=4'b1111, no control instructions, dec_valid echoes each tid one cycle after fetch.
  - Expected: tid_f sequence 0,1,2,3,0…; each thread's pc_f advances 0x0, 0x4, 0x8 on successive visits.
- Thread 1 decodes a branch (dec_ctrl=1), resolved 3 cycles later with res_taken=1, res_target=0x100.
  - Expected: thread 1 is skipped (sequence 0,2,3,0,2…) until resolution; its next fetch has pc_f=0x100, pc_plus4_f=0x104.
- Same scenario with res_taken=0.
  - Expected: thread 1 resumes at pc_f=0x8 (the fall-through).
- stall_f held high for 3 cycles mid-sequence.
  - Expected: outputs frozen including fetch_valid_f=1; no PC advances; after release the RR order continues from the frozen thread+1.
- en_mask=4'b0001, single thread.
  - Expected: fetch_valid_f toggles 1,0,1,0; pc_f values 0x0, 0x4, 0x8.
- en_mask=0, then rst asserted while thread 2 is BLOCKED.
  - Expected with en_mask=0: fetch_valid_f=0.
  - Expected after reset: all PCs=RESET_PC, all threads IDLE, and the first fetch after re-enable is tid 0.

Source files
------------

// File: rtl/mt_pkg.sv
// mt_pkg: shared thread-state encoding and sizing helpers for the multithreaded RV32 core
package mt_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2,
    BLOCKED  = 2'd3
  } thread_state_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  function automatic int bits_threads(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the pointer
module rr_arbiter
  import mt_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  localparam int B = bits_threads(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [B-1:0]           ptr,
  output logic [NUM_THREADS-1:0] gnt,
  output logic [B-1:0]           idx,
  output logic                   valid
);
  // scan farthest-first so the nearest request after ptr overwrites the others
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      if (req[ptr + B'(i)]) begin
        idx = ptr + B'(i);
        valid = 1'b1;
      end
    end
  end
  assign gnt = valid ? (NUM_THREADS'(1) << idx) : '0;
endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: per-thread PCs and states, round-robin fetch pick, parks threads on unresolved control flow
module thread_scheduler
  import mt_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_THREADS-1:0]   en_mask,
  input  logic                     stall_f,
  input  logic                     dec_valid,
  input  logic [BITS_THREADS-1:0]  dec_tid,
  input  logic                     dec_ctrl,
  input  logic                     res_valid,
  input  logic [BITS_THREADS-1:0]  res_tid,
  input  logic                     res_taken,
  input  logic [ADDRESS_WIDTH-1:0] res_target,
  output logic                     fetch_valid_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f
);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);
  thread_state_t state_q [NUM_THREADS];
  thread_state_t state_d [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [BITS_THREADS-1:0] ptr_q, grant_idx, tid_q;
  logic [NUM_THREADS-1:0] elig, gnt;
  logic grant_valid, issue, fetch_valid_q;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_plus4_q;

  always_comb
    for (int t = 0; t < NUM_THREADS; t++)
      elig[t] = (state_q[t] == READY) && en_mask[t];

  rr_arbiter #(.NUM_THREADS(NUM_THREADS)) u_arb (
    .req  (elig),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .idx  (grant_idx),
    .valid(grant_valid)
  );

  assign issue = grant_valid && !stall_f;

  // INFLIGHT/BLOCKED ignore en_mask so a disabled thread drains before going IDLE
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      case (state_q[t])
        IDLE: state_d[t] = en_mask[t] ? READY : IDLE;
        READY: begin
          state_d[t] = (issue && gnt[t]) ? INFLIGHT : en_mask[t] ? READY : IDLE;
          pc_d[t] = (issue && gnt[t]) ? pc_q[t] + FOUR : pc_q[t];
        end
        INFLIGHT:
          if (dec_valid && dec_tid == BITS_THREADS'(t)) state_d[t] = dec_ctrl ? BLOCKED : READY;
        BLOCKED:
          if (res_valid && res_tid == BITS_THREADS'(t)) begin
            state_d[t] = READY;
            pc_d[t] = res_taken ? res_target : pc_q[t];
          end
        default: state_d[t] = state_q[t];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= IDLE;
        pc_q[t] <= RESET_PC;
      end
      ptr_q <= BITS_THREADS'(NUM_THREADS - 1);
      fetch_valid_q <= 1'b0;
      tid_q <= '0;
      pc_f_q <= RESET_PC;
      pc_plus4_q <= RESET_PC + FOUR;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      if (issue) begin
        ptr_q <= grant_idx;
        fetch_valid_q <= 1'b1;
        tid_q <= grant_idx;
        pc_f_q <= pc_q[grant_idx];
        pc_plus4_q <= pc_q[grant_idx] + FOUR;
      end else if (!stall_f) begin
        fetch_valid_q <= 1'b0;
      end
    end
  end

  // decode/resolve reports must target a thread in the matching state
  always_ff @(posedge clk) begin
    if (!rst && dec_valid)
      assert (state_q[dec_tid] == INFLIGHT) else $error("dec_valid for thread %0d not INFLIGHT", dec_tid);
    if (!rst && res_valid)
      assert (state_q[res_tid] == BLOCKED) else $error("res_valid for thread %0d not BLOCKED", res_tid);
  end

  assign fetch_valid_f = fetch_valid_q;
  assign tid_f = tid_q;
  assign pc_f = pc_f_q;
  assign pc_plus4_f = pc_plus4_q;
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed vectors with hand-computed fetch sequences for thread_scheduler
module tb_thread_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] en_mask = '0;
  logic stall_f = 1'b0, dec_valid = 1'b0, dec_ctrl = 1'b0;
  logic [1:0] dec_tid = '0, res_tid = '0;
  logic res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic fetch_valid_f;
  logic [1:0] tid_f;
  logic [31:0] pc_f, pc_plus4_f;
  int n_chk = 0, n_err = 0;
  int br_tid = -1;
  logic [31:0] br_pc = '0;

  thread_scheduler dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .stall_f(stall_f),
    .dec_valid(dec_valid), .dec_tid(dec_tid), .dec_ctrl(dec_ctrl),
    .res_valid(res_valid), .res_tid(res_tid), .res_taken(res_taken), .res_target(res_target),
    .fetch_valid_f(fetch_valid_f), .tid_f(tid_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock; then decode echoes the fetch that just appeared (branch marked by br_tid/br_pc)
  task automatic tick();
    logic s;
    s = stall_f;
    @(posedge clk);
    #1;
    dec_valid = fetch_valid_f && !s;
    dec_tid = tid_f;
    dec_ctrl = dec_valid && int'(tid_f) == br_tid && pc_f == br_pc;
    res_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input int tid, input logic [31:0] pc);
    chk($sformatf("%s valid", tag), {31'b0, fetch_valid_f}, 32'd1);
    chk($sformatf("%s tid", tag), {30'b0, tid_f}, tid);
    chk($sformatf("%s pc", tag), pc_f, pc);
    chk($sformatf("%s pc4", tag), pc_plus4_f, pc + 32'd4);
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s valid", tag), {31'b0, fetch_valid_f}, 32'd0);
    chk($sformatf("%s tid", tag), {30'b0, tid_f}, 32'd0);
    chk($sformatf("%s pc", tag), pc_f, 32'h0);
    chk($sformatf("%s pc4", tag), pc_plus4_f, 32'h4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en_mask = '0;
    stall_f = 1'b0;
    br_tid = -1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int btid[13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 1};
    logic [31:0] bpc[12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC};
    // all threads enabled, straight-line code
    do_reset();
    chk_reset("s1 reset");
    en_mask = 4'hF;
    tick();
    chk("s1 idle valid", {31'b0, fetch_valid_f}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      fetch($sformatf("s1[%0d]", k), k % 4, 32'(4 * (k / 4)));
    end
    // thread 1 branches at pc 0x4, resolved taken then not-taken
    for (int tk = 1; tk >= 0; tk--) begin
      do_reset();
      br_tid = 1;
      br_pc = 32'h4;
      en_mask = 4'hF;
      tick();
      for (int k = 0; k < 13; k++) begin
        tick();
        fetch($sformatf("br%0d[%0d]", tk, k), btid[k], k == 12 ? (tk == 1 ? 32'h100 : 32'h8) : bpc[k]);
        if (k == 8) begin
          res_valid = 1'b1;
          res_tid = 2'd1;
          res_taken = tk[0];
          res_target = 32'h100;
        end
      end
    end
    // three-cycle stall after thread 2 is fetched
    do_reset();
    en_mask = 4'hF;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      fetch($sformatf("st pre[%0d]", k), k, 32'h0);
    end
    stall_f = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      fetch($sformatf("st hold[%0d]", k), 2, 32'h0);
    end
    stall_f = 1'b0;
    tick();
    fetch("st post0", 3, 32'h0);
    tick();
    fetch("st post1", 0, 32'h4);
    tick();
    fetch("st post2", 1, 32'h4);
    // single enabled thread alternates fetch and gap
    do_reset();
    en_mask = 4'h1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) fetch($sformatf("one[%0d]", k), 0, 32'(4 * (k / 2)));
      else begin
        chk($sformatf("one[%0d] valid", k), {31'b0, fetch_valid_f}, 32'd0);
        chk($sformatf("one[%0d] pc hold", k), pc_f, 32'(4 * (k / 2)));
      end
    end
    // disable all, reset while thread 2 is blocked
    do_reset();
    br_tid = 2;
    br_pc = 32'h0;
    en_mask = 4'hF;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      fetch($sformatf("rb pre[%0d]", k), k, 32'h0);
    end
    en_mask = 4'h0;
    tick();
    chk("rb off0 valid", {31'b0, fetch_valid_f}, 32'd0);
    tick();
    chk("rb off1 valid", {31'b0, fetch_valid_f}, 32'd0);
    rst = 1'b1;
    br_tid = -1;
    tick();
    rst = 1'b0;
    chk_reset("rb reset");
    en_mask = 4'hF;
    tick();
    chk("rb idle valid", {31'b0, fetch_valid_f}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      fetch($sformatf("rb post[%0d]", k), k, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
